// File: rtl/axi_st_patgen_top.sv
// AXI-ST LFSR pattern generator: counted or continuous bursts, forwarding accepted beats to the checker.
// Optional error injection (input err_inj) is built in when PATGEN_ERR_INJ_EN is defined.
module axi_st_patgen_top #(
  parameter int unsigned LEADER_MODE = 1,
  parameter logic [31:0] SEED        = 32'hACE1_2345,
  localparam int unsigned DW         = LEADER_MODE * 256,
  localparam int unsigned NL         = DW / 32
) (
  input  logic          rdclk,
  input  logic          rst_n,
  input  logic          patgen_en,
  input  logic [8:0]    patgen_num,
  input  logic          cntuspatt_en,
  input  logic          chkr_fifo_full,
  input  logic          axist_tready,
`ifdef PATGEN_ERR_INJ_EN
  input  logic          err_inj,
`endif
  output logic          axist_valid,
  output logic [DW-1:0] axist_tdata,
  output logic [DW-1:0] patgen_din,
  output logic          patgen_din_wr,
  output logic [8:0]    patgen_cnt,
  output logic          patgen_done
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t      state;
  logic        en_q, en_qq, cn_q, cn_qq;
  logic        cont_mode;
  logic [8:0]  remaining;
  logic [31:0] lfsr;

  logic        start_cnt, start_cont;
  logic        acc, stopping, launch, finish;
  logic [31:0] lfsr_nxt;
  logic [8:0]  rem_nxt;
  logic        inj_bit, corrupt;

  // Galois form, taps x^32+x^22+x^2+x+1
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction

  function automatic logic [DW-1:0] beat_of(input logic [31:0] s);
    logic [DW-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < NL; i++) b[32*i +: 32] = s + 32'(i);
    return b;
  endfunction

  assign start_cnt  = en_q & ~en_qq;
  assign start_cont = cn_q & ~cn_qq;

  // The next beat is built from the post-accept LFSR so back-to-back launches keep 1 beat/cycle.
  always_comb begin
    acc      = axist_valid & axist_tready;
    lfsr_nxt = acc ? lfsr_step(lfsr) : lfsr;
    rem_nxt  = acc ? remaining - 9'd1 : remaining;
    stopping = cont_mode & ~cn_q;
    launch   = (state == SEND) && (!axist_valid || acc) && !chkr_fifo_full &&
               (cont_mode ? !stopping : (rem_nxt != '0));
    finish   = (state == SEND) &&
               (cont_mode ? (stopping && (!axist_valid || acc)) : (acc && rem_nxt == '0));
  end

`ifdef PATGEN_ERR_INJ_EN
  logic armed;

  // corrupt tracks whether the beat currently on the bus was flipped, so patgen_din can undo it.
  always_ff @(posedge rdclk) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      corrupt <= 1'b0;
    end else if (launch) begin
      corrupt <= armed;
      armed   <= err_inj;
    end else begin
      armed   <= armed | err_inj;
    end
  end

  assign inj_bit = armed;
`else
  assign inj_bit = 1'b0;
  assign corrupt = 1'b0;
`endif

  always_ff @(posedge rdclk) begin
    if (!rst_n) begin
      state         <= IDLE;
      en_q          <= 1'b0;
      en_qq         <= 1'b0;
      cn_q          <= 1'b0;
      cn_qq         <= 1'b0;
      cont_mode     <= 1'b0;
      remaining     <= '0;
      lfsr          <= SEED;
      axist_valid   <= 1'b0;
      axist_tdata   <= '0;
      patgen_din    <= '0;
      patgen_din_wr <= 1'b0;
      patgen_cnt    <= '0;
      patgen_done   <= 1'b0;
    end else begin
      en_q          <= patgen_en;
      en_qq         <= en_q;
      cn_q          <= cntuspatt_en;
      cn_qq         <= cn_q;
      patgen_din_wr <= acc;
      if (acc) begin
        patgen_din <= axist_tdata ^ DW'(corrupt);
        patgen_cnt <= patgen_cnt + 9'd1;
        remaining  <= rem_nxt;
        lfsr       <= lfsr_nxt;
      end
      case (state)
        IDLE, DONE: begin
          if (start_cont) begin
            state       <= SEND;
            cont_mode   <= 1'b1;
            patgen_cnt  <= '0;
            patgen_done <= 1'b0;
            lfsr        <= SEED;
          end else if (start_cnt) begin
            cont_mode  <= 1'b0;
            patgen_cnt <= '0;
            lfsr       <= SEED;
            if (patgen_num != '0) begin
              state       <= SEND;
              remaining   <= patgen_num;
              patgen_done <= 1'b0;
            end else begin
              state       <= DONE;
              patgen_done <= 1'b1;
            end
          end
        end
        SEND: begin
          if (launch) begin
            axist_valid <= 1'b1;
            axist_tdata <= beat_of(lfsr_nxt) ^ DW'(inj_bit);
          end else if (acc) begin
            axist_valid <= 1'b0;
          end
          if (finish) begin
            state       <= DONE;
            patgen_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
